// File: rtl/pipe_pkg.sv
// Shared pipeline types: in-flight destination tag and EX operand forward-select encoding.
package pipe_pkg;

  // Tag rd width; hazard_forward_ctrl's REG_AW must not exceed this.
  localparam int TAG_RD_W = 5;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                wr;
    logic                load;
  } tag_t;

  localparam tag_t TAG_NONE = '0;

  function automatic logic tag_live(input tag_t t, input logic zero_fwd);
    return t.valid & t.wr & ((t.rd != '0) | zero_fwd);
  endfunction

endpackage

// File: rtl/hfc_src_match.sv
// One source operand against the EX and MEM tags: picks the youngest producer
// and flags a load sitting in EX (a load-use hazard).
module hfc_src_match
  import pipe_pkg::*;
#(
  parameter int ZERO_REG_FWD = 0
) (
  input  logic [TAG_RD_W-1:0] src,
  input  logic                src_used,
  input  tag_t                ex_tag,
  input  tag_t                mem_tag,
  output logic [1:0]          sel,
  output logic                load_hit
);

  localparam logic ZERO_FWD = (ZERO_REG_FWD != 0);

  logic ex_match;
  logic mem_match;
  logic unused_mem_load;

  assign ex_match  = src_used & tag_live(ex_tag, ZERO_FWD) & (src == ex_tag.rd);
  assign mem_match = src_used & tag_live(mem_tag, ZERO_FWD) & (src == mem_tag.rd);

  // A load in MEM forwards like any other result, so its load bit is irrelevant here.
  assign unused_mem_load = mem_tag.load;

  always_comb begin
    sel = FWD_RF;
    if (ex_match) begin
      sel = FWD_EXMEM;
    end else if (mem_match) begin
      sel = FWD_MEMWB;
    end
  end

  assign load_hit = ex_match & ex_tag.load;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Tracks in-flight destination tags and produces registered EX forward selects
// plus a combinational one-cycle load-use stall for the instruction in ID.
module hazard_forward_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int ZERO_REG_FWD = 0,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              ex_bubble,
  output logic [CNT_W-1:0]  stall_count
);

  tag_t             ex_q, ex_d;
  tag_t             mem_q, mem_d;
  tag_t             wb_q, wb_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic             bubble_q, bubble_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  tag_t       id_tag;
  logic [1:0] sel_a, sel_b;
  logic       load_hit_a, load_hit_b;
  logic       stall_c;
  logic       unused_wb;

  assign id_tag = '{valid: 1'b1, rd: TAG_RD_W'(id_rd), wr: id_wr_en, load: id_is_load};

  hfc_src_match #(.ZERO_REG_FWD(ZERO_REG_FWD)) u_match_a (
    .src      (TAG_RD_W'(id_rs)),
    .src_used (id_rs_used),
    .ex_tag   (ex_q),
    .mem_tag  (mem_q),
    .sel      (sel_a),
    .load_hit (load_hit_a)
  );

  hfc_src_match #(.ZERO_REG_FWD(ZERO_REG_FWD)) u_match_b (
    .src      (TAG_RD_W'(id_rt)),
    .src_used (id_rt_used),
    .ex_tag   (ex_q),
    .mem_tag  (mem_q),
    .sel      (sel_b),
    .load_hit (load_hit_b)
  );

  // Flush dominates: a squashed instruction must never hold the front end.
  assign stall_c = rst_n & id_valid & ~flush & (load_hit_a | load_hit_b);

  // WB never forwards: the register file writes first half-cycle, reads second.
  assign unused_wb = ^wb_q;

  always_comb begin
    wb_d     = mem_q;
    mem_d    = ex_q;
    ex_d     = TAG_NONE;
    bubble_d = 1'b1;
    fwd_a_d  = FWD_RF;
    fwd_b_d  = FWD_RF;
    cnt_d    = cnt_q;
    if (id_valid && !flush && !stall_c) begin
      ex_d     = id_tag;
      bubble_d = 1'b0;
      fwd_a_d  = sel_a;
      fwd_b_d  = sel_b;
    end
    if (stall_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q     <= TAG_NONE;
      mem_q    <= TAG_NONE;
      wb_q     <= TAG_NONE;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
      bubble_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      bubble_q <= bubble_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stall       = stall_c;
  assign fwd_a_sel   = fwd_a_q;
  assign fwd_b_sel   = fwd_b_q;
  assign ex_bubble   = bubble_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl; small CNT_W makes saturation reachable.
module tb_hazard_forward_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [4:0]       id_rs, id_rt, id_rd;
  logic             id_rs_used, id_rt_used, id_wr_en, id_is_load;
  logic             flush;
  logic             stall;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             ex_bubble;
  logic [CNT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  hazard_forward_ctrl #(.REG_AW(5), .ZERO_REG_FWD(0), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .id_rd       (id_rd),
    .id_wr_en    (id_wr_en),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .stall       (stall),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .ex_bubble   (ex_bubble),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one ID-stage instruction.
  task automatic issue(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                       input logic rtu, input logic [4:0] rd, input logic wr,
                       input logic ld, input logic fl);
    id_valid   = 1'b1;
    id_rs      = rs;
    id_rs_used = rsu;
    id_rt      = rt;
    id_rt_used = rtu;
    id_rd      = rd;
    id_wr_en   = wr;
    id_is_load = ld;
    flush      = fl;
    #1;
  endtask

  task automatic idle();
    id_valid   = 1'b0;
    id_rs      = '0;
    id_rs_used = 1'b0;
    id_rt      = '0;
    id_rt_used = 1'b0;
    id_rd      = '0;
    id_wr_en   = 1'b0;
    id_is_load = 1'b0;
    flush      = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_stall", stall, 0);
    chk("rst_fwd_a", fwd_a_sel, 0);
    chk("rst_fwd_b", fwd_b_sel, 0);
    chk("rst_bubble", ex_bubble, 1);
    chk("rst_count", stall_count, 0);
    rst_n = 1'b1;

    // andi s5,s4,0xff ; slt s7,s5,s6
    issue(5'd20, 1, 5'd0, 0, 5'd21, 1, 0, 0);
    chk("andi_stall", stall, 0);
    tick();
    issue(5'd21, 1, 5'd22, 1, 5'd23, 1, 0, 0);
    chk("slt_stall", stall, 0);
    tick();
    chk("slt_fwd_a", fwd_a_sel, 1);
    chk("slt_fwd_b", fwd_b_sel, 0);
    chk("slt_bubble", ex_bubble, 0);
    idle();
    tick();

    // producer r21, unrelated, consumer of r21
    issue(5'd1, 1, 5'd0, 0, 5'd21, 1, 0, 0);
    tick();
    issue(5'd2, 1, 5'd0, 0, 5'd3, 1, 0, 0);
    tick();
    issue(5'd21, 1, 5'd5, 1, 5'd6, 1, 0, 0);
    tick();
    chk("gap1_fwd_a", fwd_a_sel, 2);
    chk("gap1_fwd_b", fwd_b_sel, 0);
    idle();
    tick();

    // lw r8 ; add r9,r8,r8
    issue(5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0);
    tick();
    issue(5'd8, 1, 5'd8, 1, 5'd9, 1, 0, 0);
    chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble", ex_bubble, 1);
    chk("lu_count", stall_count, 1);
    chk("lu_bub_fwd_a", fwd_a_sel, 0);
    chk("lu_stall_clear", stall, 0);
    tick();
    chk("lu_fwd_a", fwd_a_sel, 2);
    chk("lu_fwd_b", fwd_b_sel, 2);
    chk("lu_issue_bubble", ex_bubble, 0);
    chk("lu_count_hold", stall_count, 1);
    idle();
    tick();

    // two producers of r10, youngest wins
    issue(5'd1, 1, 5'd0, 0, 5'd10, 1, 0, 0);
    tick();
    issue(5'd2, 1, 5'd0, 0, 5'd10, 1, 0, 0);
    tick();
    issue(5'd10, 1, 5'd10, 1, 5'd11, 1, 0, 0);
    tick();
    chk("young_fwd_a", fwd_a_sel, 1);
    chk("young_fwd_b", fwd_b_sel, 1);

    // r0 destination never forwards; unused source never forwards
    issue(5'd1, 1, 5'd0, 0, 5'd0, 1, 0, 0);
    tick();
    issue(5'd0, 1, 5'd0, 1, 5'd12, 1, 0, 0);
    tick();
    chk("r0_fwd_a", fwd_a_sel, 0);
    chk("r0_fwd_b", fwd_b_sel, 0);
    issue(5'd12, 0, 5'd12, 1, 5'd13, 1, 0, 0);
    tick();
    chk("unused_fwd_a", fwd_a_sel, 0);
    chk("used_fwd_b", fwd_b_sel, 1);
    idle();
    tick();

    // lw r8 ; add r9,r8,r1 flushed in ID
    issue(5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0);
    tick();
    issue(5'd8, 1, 5'd1, 1, 5'd9, 1, 0, 1);
    chk("flush_stall", stall, 0);
    tick();
    chk("flush_bubble", ex_bubble, 1);
    chk("flush_fwd_a", fwd_a_sel, 0);
    chk("flush_count", stall_count, 1);
    idle();
    tick();

    // reset in mid-stall
    issue(5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0);
    tick();
    issue(5'd8, 1, 5'd8, 1, 5'd9, 1, 0, 0);
    chk("mid_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_forces_stall0", stall, 0);
    tick();
    chk("mid_rst_fwd_a", fwd_a_sel, 0);
    chk("mid_rst_fwd_b", fwd_b_sel, 0);
    chk("mid_rst_bubble", ex_bubble, 1);
    chk("mid_rst_count", stall_count, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_stall", stall, 0);
    idle();
    tick();

    // drive the counter to saturation
    for (int i = 0; i < 16; i++) begin
      issue(5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0);
      tick();
      issue(5'd8, 1, 5'd0, 0, 5'd9, 1, 0, 0);
      tick();
      idle();
      tick();
      if (i == 14) chk("sat_reach", stall_count, 15);
    end
    chk("sat_hold", stall_count, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Producer side of EX-stage operand forwarding for the 5-stage pipeline (IF/ID/EX/MEM/WB). It tracks the destination tags of in-flight instructions and compares each decoded instruction's sources against them. It outputs registered forward selects that drive the EX operand muxes, plus a one-cycle load-use stall. It sits beside the ID/EX pipeline register in Top and is the block whose results the ALU-to-ALU forwarding bench checks.

Parameters:
REG_AW, 5, register-index width (32 architectural registers)
ZERO_REG_FWD, 0, 0 = register 0 never matches or forwards; 1 = treated as an ordinary register
CNT_W, 16, width of the saturating stall counter

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  synchronous active-low reset
id_valid  input  1  ID holds a real instruction
id_rs  input  REG_AW  source A index
id_rt  input  REG_AW  source B index
id_rs_used  input  1  source A is read
id_rt_used  input  1  source B is read
id_rd  input  REG_AW  destination index
id_wr_en  input  1  instruction writes id_rd
id_is_load  input  1  instruction is a load (result available at end of MEM)
flush  input  1  squash the ID instruction (branch redirect)
stall  output  1  hold PC and IF/ID; combinational from ID inputs and ex tag
fwd_a_sel  output  2  registered EX mux select, operand A: 0 regfile, 1 EX/MEM ALU result, 2 MEM/WB result, 3 unused
fwd_b_sel  output  2  same encoding, operand B
ex_bubble  output  1  registered; EX holds an inserted bubble
stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst_n low at a clk edge): ex/mem/wb tags invalid; fwd_a_sel=fwd_b_sel=0; ex_bubble=1; stall_count=0. stall is forced 0 while rst_n is low.
- Each tag holds {valid, rd, wr, load}. A tag is "live" when valid and wr are both set, and rd is nonzero or ZERO_REG_FWD=1.
- match(src, tag): src_used, tag live, and src == tag.rd.
- stall = id_valid & !flush & (match(rs, ex) | match(rt, ex)) & ex.load.
- Per edge (rst_n high): wb <= mem; mem <= ex.
  - If flush or stall or !id_valid: ex <= invalid; ex_bubble <= 1; fwd selects <= 0.
  - Otherwise: ex <= ID tag; ex_bubble <= 0; each fwd select <= 1 if match(src, ex), else 2 if match(src, mem), else 0.
- Priority: the youngest producer wins. An ex match takes precedence over a mem match for the same register.
- A wb-stage match needs no forwarding. The register file writes in the first half-cycle and reads in the second.
- Load-use: exactly one stall cycle. On the next cycle the load sits in mem, so the held ID instruction gets select 2.
- A load in mem that matches ID needs no stall; it gets select 2.
- flush and stall in the same cycle: flush wins. stall=0 and a bubble is inserted.
- stall_count increments on each edge where stall=1 and saturates at all-ones.
- Latency: selects are valid in the cycle the consumer occupies EX, one edge after ID.
- Reset in mid-stall drops all in-flight tags.

Decomposition:
- Shared package pipe_pkg: the forward-select constants FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2, and the tag struct type (valid, rd, wr, load).
- One sub-module, hfc_src_match (pure combinational). It takes one source plus the ex and mem tags and returns {sel, load_hit}. It is instantiated twice, once for operand A and once for operand B.

Test Plan:
- andi s5(21),s4(20),0xff then slt s7(23),s5,s6(22) back-to-back -> slt in EX: fwd_a_sel=1, fwd_b_sel=0, stall never asserted.
- Producer into r21, one unrelated instruction, then a consumer of r21 -> fwd_a_sel=2 for the consumer.
- lw r8 then add r9,r8,r8 -> stall=1 for one cycle, ex_bubble=1, stall_count=1; then fwd_a_sel=fwd_b_sel=2.
- Producers into r10 on two consecutive cycles, then a consumer of r10 -> fwd_a_sel=1 (youngest wins). Destination r0 with ZERO_REG_FWD=0 -> select stays 0.
- lw r8 then add r9,r8,r1 with flush asserted on the add's ID cycle -> stall=0, bubble inserted, stall_count unchanged.
- rst_n low during a load-use stall -> next cycle stall=0, selects 0, ex_bubble=1, stall_count=0. Force stall_count to all-ones -> it holds at all-ones.
